// File: rtl/keypad_scan_display_pkg.sv
// Shared types and tables for the 4x4 keypad scanner and 7-segment display.
package keypad_pkg;

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_PRESS, ST_RELEASE} state_t;

  // Indexed by {row, col}; element 0 is listed last.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  // {a,b,c,d,e,f,g} for hex digits F down to 0.
  localparam logic [15:0][6:0] SEG_PAT = {
    7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
    7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
    7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
    7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
  };

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic one_low(input logic [3:0] c);
    return ($countones(~c) == 1);
  endfunction

  function automatic logic [1:0] low_idx(input logic [3:0] c);
    logic [1:0] idx;
    idx = 2'd0;
    if (!c[1]) idx = 2'd1;
    if (!c[2]) idx = 2'd2;
    if (!c[3]) idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_display_if.sv
// Pin-level bundle between the keypad/display block and the board.
interface keypad_scan_display_if #(parameter int DIGITS = 4);
  logic [3:0]          col;
  logic [3:0]          row;
  logic [DIGITS-1:0]   en;
  logic [6:0]          seg;
  logic                key_valid;
  logic [3:0]          key_code;
  logic [4*DIGITS-1:0] value;

  modport master (input col, output row, en, seg, key_valid, key_code, value);
  modport slave  (output col, input row, en, seg, key_valid, key_code, value);
endinterface

// File: rtl/keypad_scan_display_hex_to_7seg.sv
// Combinational nibble to {a..g} segment decoder.
import keypad_pkg::*;

module hex_to_7seg (
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  assign o_seg = SEG_PAT[i_nib];
endmodule

// File: rtl/keypad_scan_display.sv
// 4x4 keypad scanner with debounce, hex entry register and muxed 7-seg display.
// Optional `define KEYPAD_LEAD_BLANK_EN blanks leading zero digits.
import keypad_pkg::*;

module keypad_scan_display #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8,
  parameter int REFRESH_DIV  = 2000
) (
  input logic clk,
  input logic rst_n,
  keypad_scan_display_if.master bus
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t              r_state;
  logic [SW-1:0]       r_scan_cnt;
  logic [CW-1:0]       r_cnt;
  logic [1:0]          r_row_idx;
  logic [3:0]          r_row;
  logic [3:0]          r_pat;
  logic                r_key_valid;
  logic [3:0]          r_key_code;
  logic [4*DIGITS-1:0] r_value;
  logic [RW-1:0]       r_ref_cnt;
  logic [DW-1:0]       r_dig;
  logic [DIGITS-1:0]   r_en;
  logic [6:0]          r_seg;

  logic                w_step_end;
  logic [3:0]          w_code;
  logic [4*DIGITS-1:0] w_next_value;
  logic [3:0]          w_nib;
  logic [6:0]          w_seg;
  logic                w_blank;

  assign w_step_end = (r_scan_cnt == SW'(SCAN_DIV - 1));
  assign w_code     = KEY_MAP[{r_row_idx, low_idx(r_pat)}];

  generate
    if (DIGITS == 1) begin : g_one
      assign w_next_value = w_code;
    end else begin : g_shift
      assign w_next_value = {r_value[4*DIGITS-5:0], w_code};
    end
  endgenerate

  // Row drive follows the row index one cycle later; columns are only
  // sampled at step end, long after the row has settled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_SCAN;
      r_scan_cnt  <= '0;
      r_cnt       <= '0;
      r_row_idx   <= 2'd0;
      r_row       <= 4'b1111;
      r_pat       <= 4'b1111;
      r_key_valid <= 1'b0;
      r_key_code  <= 4'h0;
      r_value     <= '0;
    end else begin
      r_key_valid <= 1'b0;
      r_scan_cnt  <= w_step_end ? '0 : r_scan_cnt + 1'b1;
      r_row       <= ~(4'b0001 << r_row_idx);
      case (r_state)
        ST_SCAN: if (w_step_end) begin
          if (one_low(bus.col)) begin
            r_pat   <= bus.col;
            r_cnt   <= CW'(1);
            r_state <= (DEBOUNCE_CNT == 1) ? ST_PRESS : ST_DEBOUNCE;
          end else begin
            r_row_idx <= r_row_idx + 2'd1;
          end
        end
        ST_DEBOUNCE: if (w_step_end) begin
          if (bus.col == r_pat) begin
            if (r_cnt == CW'(DEBOUNCE_CNT - 1)) r_state <= ST_PRESS;
            else                                r_cnt   <= r_cnt + 1'b1;
          end else begin
            r_state   <= ST_SCAN;
            r_row_idx <= r_row_idx + 2'd1;
          end
        end
        ST_PRESS: begin
          r_key_valid <= 1'b1;
          r_key_code  <= w_code;
          r_value     <= w_next_value;
          r_cnt       <= '0;
          r_state     <= ST_RELEASE;
        end
        ST_RELEASE: if (w_step_end) begin
          if (bus.col == 4'b1111) begin
            if (r_cnt == CW'(DEBOUNCE_CNT - 1)) begin
              r_cnt     <= '0;
              r_state   <= ST_SCAN;
              r_row_idx <= r_row_idx + 2'd1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_cnt <= '0;
          end
        end
        default: r_state <= ST_SCAN;
      endcase
    end
  end

  assign w_nib = r_value[4*r_dig +: 4];

  hex_to_7seg u_hex (.i_nib(w_nib), .o_seg(w_seg));

`ifdef KEYPAD_LEAD_BLANK_EN
  logic [DW-1:0] w_msnz;
  always_comb begin
    w_msnz = '0;
    for (int i = 0; i < DIGITS; i++)
      if (r_value[4*i +: 4] != 4'h0) w_msnz = DW'(i);
  end
  assign w_blank = (r_dig > w_msnz);
`else
  assign w_blank = 1'b0;
`endif

  // Display refresh is free-running; en and seg come from the same index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ref_cnt <= '0;
      r_dig     <= '0;
      r_en      <= '1;
      r_seg     <= SEG_BLANK;
    end else begin
      r_en  <= ~(DIGITS'(1) << r_dig);
      r_seg <= w_blank ? SEG_BLANK : w_seg;
      if (r_ref_cnt == RW'(REFRESH_DIV - 1)) begin
        r_ref_cnt <= '0;
        r_dig     <= (r_dig == DW'(DIGITS - 1)) ? '0 : r_dig + 1'b1;
      end else begin
        r_ref_cnt <= r_ref_cnt + 1'b1;
      end
    end
  end

  assign bus.row       = r_row;
  assign bus.en        = r_en;
  assign bus.seg       = r_seg;
  assign bus.key_valid = r_key_valid;
  assign bus.key_code  = r_key_code;
  assign bus.value     = r_value;

endmodule

// File: tb/tb_keypad_scan_display.sv
// Self-checking bench: keypad matrix emulation plus a key/display reference model.
module tb_keypad_scan_display;
  localparam int DIGITS = 4, SCAN_DIV = 4, DEB = 3, REF = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keypad_scan_display_if #(.DIGITS(DIGITS)) bus ();

  keypad_scan_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB),
                        .REFRESH_DIV(REF)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic       key_on = 1'b0;
  int         key_r = 0, key_c = 0;
  logic       force_en = 1'b0;
  logic [3:0] col_force = 4'hF;

  // A pressed key pulls its column low only while its row is driven.
  assign bus.col = force_en ? col_force :
                   (key_on && bus.row[key_r] == 1'b0) ? 4'(~(4'b0001 << key_c)) : 4'hF;

  logic [3:0] kmap [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA}, '{4'h4, 4'h5, 4'h6, 4'hB},
                              '{4'h7, 4'h8, 4'h9, 4'hC}, '{4'hE, 4'h0, 4'hF, 4'hD}};
  logic [6:0] pat [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  int          n_assert = 0, n_fail = 0, pulses = 0;
  logic [3:0]  codes [$];
  logic [15:0] exp_value = '0;
  logic [3:0]  exp_code = '0;

  always @(negedge clk)
    if (rst_n && bus.key_valid === 1'b1) begin
      pulses++;
      codes.push_back(bus.key_code);
    end

  task automatic tick(int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(int d);
`ifdef KEYPAD_LEAD_BLANK_EN
    int msnz = 0;
    for (int i = 0; i < DIGITS; i++) if (exp_value[4*i +: 4] != 4'h0) msnz = i;
    if (d > msnz) return 7'b0000000;
`endif
    return pat[exp_value[4*d +: 4]];
  endfunction

  task automatic chk_reset_vals(string tag);
    chk({tag, "_row"}, bus.row, 4'hF);
    chk({tag, "_en"}, bus.en, 4'hF);
    chk({tag, "_seg"}, bus.seg, 7'h0);
    chk({tag, "_valid"}, bus.key_valid, 1'b0);
    chk({tag, "_code"}, bus.key_code, 4'h0);
    chk({tag, "_value"}, bus.value, 16'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    chk_reset_vals("rst");
    exp_value = '0;
    exp_code  = '0;
    codes.delete();
    rst_n = 1'b1;
  endtask

  task automatic press_key(int r, int c, int hold, int rel);
    int p0 = pulses;
    int waited = 0;
    logic [3:0] got;
    key_r = r; key_c = c; key_on = 1'b1;
    while (pulses == p0 && waited < (DEB + 4) * SCAN_DIV + 2) begin tick(1); waited++; end
    chk("press_latency", pulses - p0, 1);
    if (hold > waited) tick(hold - waited);
    key_on = 1'b0;
    tick(rel);
    exp_code  = kmap[r][c];
    exp_value = {exp_value[11:0], exp_code};
    chk("one_pulse", pulses - p0, 1);
    chk("code_q", codes.size(), 1);
    got = (codes.size() > 0) ? codes.pop_front() : 4'bx;
    codes.delete();
    chk("pulse_code", got, exp_code);
    chk("key_code", bus.key_code, exp_code);
    chk("value", bus.value, exp_value);
  endtask

  task automatic check_display();
    for (int d = 0; d < DIGITS; d++) begin
      int w = 0;
      while (bus.en !== 4'(~(4'b0001 << d)) && w < DIGITS * REF + 2) begin tick(1); w++; end
      chk("en_found", bus.en, 4'(~(4'b0001 << d)));
      chk("disp_seg", bus.seg, exp_seg(d));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    logic [3:0] r1;
    tick(1);

    // Idle scan and display walk after reset.
    do_reset();
    p0 = pulses;
    for (int k = 1; k <= 64; k++) begin
      tick(1);
      chk("idle_row", bus.row, 4'(~(4'b0001 << (((k - 1) / SCAN_DIV) % 4))));
      chk("idle_en", bus.en, 4'(~(4'b0001 << (((k - 1) / REF) % DIGITS))));
      chk("idle_seg", bus.seg, exp_seg(((k - 1) / REF) % DIGITS));
    end
    chk("idle_no_pulse", pulses - p0, 0);

    // Directed sequence 1, 0, B.
    press_key(0, 0, 40, 40);
    press_key(3, 1, 40, 40);
    press_key(1, 3, 40, 40);
    chk("seq_value", bus.value, 16'h010B);
    check_display();

    // Bounce: alternate samples differ, never reaches the debounce count.
    p0 = pulses;
    force_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      col_force = (i % 2 == 0) ? 4'hE : 4'hF;
      tick(SCAN_DIV);
    end
    col_force = 4'hF;
    tick(8);
    chk("bounce_no_pulse", pulses - p0, 0);
    r1 = bus.row;
    tick(SCAN_DIV);
    chk("bounce_scan_resumed", bus.row != r1, 1'b1);
    force_en = 1'b0;

    // Long hold gives exactly one pulse; two columns low is ignored.
    press_key(2, 2, 200, 40);
    p0 = pulses;
    force_en = 1'b1; col_force = 4'b1100;
    tick(60);
    col_force = 4'hF; tick(8); force_en = 1'b0;
    chk("ghost_no_pulse", pulses - p0, 0);
    chk("ghost_value", bus.value, exp_value);

    // Random key sequence against the model.
    for (int i = 0; i < 6; i++)
      press_key(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 40, 40);
    check_display();

    // Leading-digit display with value 0005.
    do_reset();
    press_key(1, 1, 40, 40);
    chk("blank_value", bus.value, 16'h0005);
    check_display();

    // Reset after two matching samples discards the key.
    do_reset();
    force_en = 1'b1; col_force = 4'hE;
    tick(9);
    rst_n = 1'b0; col_force = 4'hF;
    p0 = pulses;
    tick(1);
    chk_reset_vals("midrst");
    rst_n = 1'b1;
    tick(40);
    force_en = 1'b0;
    chk("midrst_no_pulse", pulses - p0, 0);
    chk("midrst_value", bus.value, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
